// File: rtl/ad9253_spi_3wire.sv
// 3-wire SPI serial engine for the AD9253: 24-bit frames (16-bit instruction + 8 data bits),
// MSB first, SDIO released for read data and sampled on SCLK rising edges.
module ad9253_spi_3wire #(
    parameter int CLK_DIV = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_data_en,
    input  logic [23:0] wr_data,
    input  logic        rd_add_en,
    input  logic [12:0] rd_add,
    output logic        spi_csn,
    output logic        spi_clk,
    inout  wire         spi_data,
    output logic        spi_busy,
    output logic        rd_data_en,
    output logic [7:0]  rd_data
);

    localparam logic [7:0] PH_LAST = 8'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        GAP
    } state_t;

    state_t      state;
    logic [7:0]  phase_cnt;
    logic [4:0]  bit_cnt;
    logic        gap_half;
    logic        is_read;
    logic [23:0] tx_sr;
    logic [7:0]  rx_sr;
    logic        sdo;
    logic        sdo_en;

    logic        phase_end;
    logic [23:0] wr_frame;
    logic [23:0] rd_frame;
    logic        unused_ok;

    assign phase_end = (phase_cnt == PH_LAST);
    assign wr_frame  = {3'b000, wr_data[20:0]};
    assign rd_frame  = {3'b100, rd_add, 8'h00};
    assign unused_ok = ^wr_data[23:21];

    assign spi_data = sdo_en ? sdo : 1'bz;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            phase_cnt  <= '0;
            bit_cnt    <= '0;
            gap_half   <= 1'b0;
            is_read    <= 1'b0;
            tx_sr      <= '0;
            rx_sr      <= '0;
            sdo        <= 1'b0;
            sdo_en     <= 1'b0;
            spi_csn    <= 1'b1;
            spi_clk    <= 1'b0;
            spi_busy   <= 1'b0;
            rd_data_en <= 1'b0;
            rd_data    <= '0;
        end else begin
            rd_data_en <= 1'b0;
            case (state)
                IDLE: begin
                    phase_cnt <= '0;
                    bit_cnt   <= '0;
                    gap_half  <= 1'b0;
                    // Write wins a same-cycle collision; the read strobe is simply dropped.
                    if (wr_data_en || rd_add_en) begin
                        is_read  <= !wr_data_en;
                        tx_sr    <= wr_data_en ? wr_frame : rd_frame;
                        sdo      <= wr_data_en ? wr_frame[23] : rd_frame[23];
                        sdo_en   <= 1'b1;
                        spi_csn  <= 1'b0;
                        spi_busy <= 1'b1;
                        state    <= SETUP;
                    end
                end

                SETUP: begin
                    if (phase_end) begin
                        phase_cnt <= '0;
                        state     <= SHIFT;
                    end else begin
                        phase_cnt <= phase_cnt + 8'd1;
                    end
                end

                SHIFT: begin
                    if (!phase_end) begin
                        phase_cnt <= phase_cnt + 8'd1;
                    end else begin
                        phase_cnt <= '0;
                        spi_clk   <= !spi_clk;
                        if (!spi_clk) begin
                            // Rising edge: capture read data bits 7..0.
                            if (is_read && bit_cnt >= 5'd16)
                                rx_sr <= {rx_sr[6:0], spi_data};
                        end else if (bit_cnt == 5'd23) begin
                            state <= HOLD;
                        end else begin
                            // Falling edge: advance to the next bit.
                            bit_cnt <= bit_cnt + 5'd1;
                            tx_sr   <= {tx_sr[22:0], 1'b0};
                            sdo     <= tx_sr[22];
                            if (is_read && bit_cnt == 5'd15)
                                sdo_en <= 1'b0;
                        end
                    end
                end

                HOLD: begin
                    if (phase_end) begin
                        phase_cnt <= '0;
                        spi_csn   <= 1'b1;
                        sdo_en    <= 1'b0;
                        state     <= GAP;
                        if (is_read) begin
                            rd_data    <= rx_sr;
                            rd_data_en <= 1'b1;
                        end
                    end else begin
                        phase_cnt <= phase_cnt + 8'd1;
                    end
                end

                GAP: begin
                    // Two phase-counter wraps give the 2*CLK_DIV inter-frame gap.
                    if (phase_end) begin
                        phase_cnt <= '0;
                        if (gap_half) begin
                            spi_busy <= 1'b0;
                            state    <= IDLE;
                        end else begin
                            gap_half <= 1'b1;
                        end
                    end else begin
                        phase_cnt <= phase_cnt + 8'd1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ad9253_spi_3wire.sv
// Bench for ad9253_spi_3wire: three instances (CLK_DIV 4, 2, 255), each with a per-cycle timing
// model derived from the frame-timing rules, plus directed and randomized transactions.
module tb_ad9253_spi_3wire;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [2:0]       wr_en = '0;
    logic [2:0]       rd_en = '0;
    logic [2:0][23:0] wr_d  = '0;
    logic [2:0][12:0] rd_a  = '0;
    logic [2:0][7:0]  dev_v = '0;

    logic [2:0]       csn_v, sclk_v, busy_v, rde_v, mact_v;
    logic [2:0][7:0]  rdd_v, rde_cnt_v, falls_v;
    logic [2:0][15:0] mn_v, busy_len_v, csn_len_v, csn_hi_v, sclk_per_v;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input int lane, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s lane%0d: observed 0x%0h expected 0x%0h", tag, lane, obs, exp);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : lane
        localparam int D = (g == 0) ? 4 : (g == 1) ? 2 : 255;

        wire  sd;
        logic tb_oe  = 1'b0;
        logic tb_val = 1'b0;
        assign sd = tb_oe ? tb_val : 1'bz;

        ad9253_spi_3wire #(.CLK_DIV(D)) dut (
            .clk       (clk),
            .rst       (rst),
            .wr_data_en(wr_en[g]),
            .wr_data   (wr_d[g]),
            .rd_add_en (rd_en[g]),
            .rd_add    (rd_a[g]),
            .spi_csn   (csn_v[g]),
            .spi_clk   (sclk_v[g]),
            .spi_data  (sd),
            .spi_busy  (busy_v[g]),
            .rd_data_en(rde_v[g]),
            .rd_data   (rdd_v[g])
        );

        // Model: m_n counts cycles since the accept edge (1 = first busy cycle).
        logic        m_act   = 1'b0;
        logic        m_rd    = 1'b0;
        int          m_n     = 0;
        logic [23:0] m_frame = '0;
        logic [7:0]  m_dev   = '0;
        logic [7:0]  m_rdata = '0;

        always @(posedge clk or posedge rst) begin
            if (rst) begin
                m_act   <= 1'b0;
                m_n     <= 0;
                m_rdata <= '0;
            end else if (m_act) begin
                if (m_rd && m_n == 50 * D) m_rdata <= m_dev;
                if (m_n == 52 * D) m_act <= 1'b0;
                else m_n <= m_n + 1;
            end else if (wr_en[g] || rd_en[g]) begin
                m_act   <= 1'b1;
                m_n     <= 1;
                m_rd    <= !wr_en[g];
                m_frame <= wr_en[g] ? {3'b000, wr_d[g][20:0]} : {3'b100, rd_a[g], 8'h00};
                m_dev   <= dev_v[g];
            end
        end

        int   mm, k, kd;
        logic exp_sclk;
        int   cyc = 0, last_rise = 0, busy_run = 0, csn_run = 0, hi_run = 0;
        int   busy_len = 0, csn_len = 0, csn_hi = 0, sclk_per = 0, rde_cnt = 0, falls = 0;
        logic sclk_q = 1'b0;

        assign mact_v[g]     = m_act;
        assign mn_v[g]       = 16'(m_n);
        assign busy_len_v[g] = 16'(busy_len);
        assign csn_len_v[g]  = 16'(csn_len);
        assign csn_hi_v[g]   = 16'(csn_hi);
        assign sclk_per_v[g] = 16'(sclk_per);
        assign rde_cnt_v[g]  = 8'(rde_cnt);
        assign falls_v[g]    = 8'(falls);

        always @(negedge clk) begin
            mm       = m_n - 1 - D;
            exp_sclk = m_act && mm >= 0 && mm < 48 * D && ((mm / D) % 2 == 1);
            chk("busy", g, 32'(busy_v[g]), 32'(m_act));
            chk("csn", g, 32'(csn_v[g]), 32'(!(m_act && m_n <= 50 * D)));
            chk("sclk", g, 32'(sclk_v[g]), 32'(exp_sclk));
            chk("rd_data_en", g, 32'(rde_v[g]), 32'(m_act && m_rd && m_n == 50 * D + 1));
            chk("rd_data", g, 32'(rdd_v[g]), 32'(m_rdata));
            // Block drives SETUP+SHIFT (writes also through HOLD); reads stop at data bit 7.
            if (m_act && (m_n <= 49 * D || (!m_rd && m_n <= 50 * D)) && !(m_rd && m_n >= 1 + 33 * D)) begin
                k = (mm < 0) ? 0 : ((mm / (2 * D) > 23) ? 23 : mm / (2 * D));
                chk("sdio", g, 32'(sd), 32'(m_frame[23 - k]));
            end
            // Device side: present read byte MSB first from the falling edge after bit 15.
            if (m_act && m_rd && m_n >= 1 + 33 * D && m_n <= 50 * D) begin
                kd     = mm / (2 * D) - 16;
                if (kd > 7) kd = 7;
                tb_oe  = 1'b1;
                tb_val = m_dev[7 - kd];
            end else begin
                tb_oe = 1'b0;
            end

            cyc <= cyc + 1;
            if (busy_v[g]) busy_run <= busy_run + 1;
            else if (busy_run != 0) begin busy_len <= busy_run; busy_run <= 0; end
            if (!csn_v[g]) csn_run <= csn_run + 1;
            else if (csn_run != 0) begin csn_len <= csn_run; csn_run <= 0; end
            if (csn_v[g]) hi_run <= hi_run + 1;
            else if (hi_run != 0) begin csn_hi <= hi_run; hi_run <= 0; falls <= falls + 1; end
            if (rde_v[g]) rde_cnt <= rde_cnt + 1;
            if (sclk_v[g] && !sclk_q) begin
                if (last_rise != 0) sclk_per <= cyc - last_rise;
                last_rise <= cyc;
            end
            sclk_q <= sclk_v[g];
        end
    end

    task automatic do_wr(input int g, input logic [23:0] d);
        @(negedge clk);
        wr_d[g]  = d;
        wr_en[g] = 1'b1;
        @(negedge clk);
        wr_en[g] = 1'b0;
    endtask

    task automatic do_rd(input int g, input logic [12:0] a, input logic [7:0] dev);
        @(negedge clk);
        rd_a[g]  = a;
        dev_v[g] = dev;
        rd_en[g] = 1'b1;
        @(negedge clk);
        rd_en[g] = 1'b0;
    endtask

    task automatic wait_idle(input int g, input int budget);
        int c;
        c = 0;
        while (mact_v[g] && c < budget) begin
            @(negedge clk);
            c++;
        end
        chk("idle_timeout", g, 32'(mact_v[g]), 32'd0);
        repeat (2) @(negedge clk);
        #1;
    endtask

    initial begin
        int c, f0, r0;
        repeat (3) @(negedge clk);
        chk("rst_csn", 0, 32'(csn_v[0]), 32'd1);
        chk("rst_sclk", 0, 32'(sclk_v[0]), 32'd0);
        chk("rst_busy", 0, 32'(busy_v[0]), 32'd0);
        chk("rst_rd_data", 0, 32'(rdd_v[0]), 32'd0);
        rst = 1'b0;

        // Plain write
        do_wr(0, 24'h000803);
        wait_idle(0, 300);
        chk("wr_csn_low", 0, 32'(csn_len_v[0]), 32'd200);
        chk("wr_busy_len", 0, 32'(busy_len_v[0]), 32'd208);
        chk("wr_no_rde", 0, 32'(rde_cnt_v[0]), 32'd0);

        // Read returning 0x92
        r0 = int'(rde_cnt_v[0]);
        do_rd(0, 13'h0001, 8'h92);
        wait_idle(0, 300);
        chk("rd_pulses", 0, 32'(rde_cnt_v[0]), 32'(r0 + 1));
        chk("rd_value", 0, 32'(rdd_v[0]), 32'h92);

        // Collision: write wins, read dropped
        f0 = int'(falls_v[0]);
        r0 = int'(rde_cnt_v[0]);
        @(negedge clk);
        wr_d[0] = 24'h001400; rd_a[0] = 13'h0100; wr_en[0] = 1'b1; rd_en[0] = 1'b1;
        @(negedge clk);
        wr_en[0] = 1'b0; rd_en[0] = 1'b0;
        wait_idle(0, 300);
        repeat (20) @(negedge clk);
        #1;
        chk("coll_frames", 0, 32'(falls_v[0]), 32'(f0 + 1));
        chk("coll_no_rde", 0, 32'(rde_cnt_v[0]), 32'(r0));

        // Strobe during the gap is ignored
        f0 = int'(falls_v[0]);
        do_wr(0, 24'($urandom));
        c = 0;
        while (mn_v[0] <= 16'd200 && c < 400) begin @(negedge clk); c++; end
        rd_a[0] = 13'($urandom); rd_en[0] = 1'b1;
        @(negedge clk);
        rd_en[0] = 1'b0;
        wait_idle(0, 300);
        repeat (20) @(negedge clk);
        #1;
        chk("gap_ignore", 0, 32'(falls_v[0]), 32'(f0 + 1));

        // Held strobe: back-to-back frames; CSB high = 2*CLK_DIV gap plus the accepting idle cycle
        f0 = int'(falls_v[0]);
        wr_d[0] = 24'($urandom); wr_en[0] = 1'b1;
        c = 0;
        while (int'(falls_v[0]) != f0 + 2 && c < 1000) begin @(negedge clk); c++; end
        wr_en[0] = 1'b0;
        wait_idle(0, 300);
        repeat (20) @(negedge clk);
        #1;
        chk("held_frames", 0, 32'(falls_v[0]), 32'(f0 + 2));
        chk("held_gap", 0, 32'(csn_hi_v[0]), 32'd9);

        // Randomized mix against the model
        for (int i = 0; i < 8; i++) begin
            if ($urandom_range(0, 1) == 1) do_rd(0, 13'($urandom), 8'($urandom_range(1, 255)));
            else do_wr(0, 24'($urandom));
            wait_idle(0, 300);
        end
        do_rd(0, 13'($urandom), 8'($urandom_range(1, 255)));
        wait_idle(0, 300);
        chk("rand_rd_nonzero", 0, 32'(rdd_v[0] != 8'h00), 32'd1);

        // Reset during bit 10 (high phase) of a read
        r0 = int'(rde_cnt_v[0]);
        do_rd(0, 13'($urandom), 8'h5a);
        c = 0;
        while (mn_v[0] < 16'd90 && c < 400) begin @(negedge clk); c++; end
        chk("pre_rst_sclk", 0, 32'(sclk_v[0]), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_csn", 0, 32'(csn_v[0]), 32'd1);
        chk("mid_rst_sclk", 0, 32'(sclk_v[0]), 32'd0);
        chk("mid_rst_busy", 0, 32'(busy_v[0]), 32'd0);
        chk("mid_rst_rde", 0, 32'(rde_v[0]), 32'd0);
        chk("mid_rst_rd_data", 0, 32'(rdd_v[0]), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (300) @(negedge clk);
        #1;
        chk("mid_rst_no_rde", 0, 32'(rde_cnt_v[0]), 32'(r0));
        do_wr(0, 24'h00ff01);
        wait_idle(0, 300);
        chk("post_rst_busy_len", 0, 32'(busy_len_v[0]), 32'd208);
        chk("post_rst_csn_low", 0, 32'(csn_len_v[0]), 32'd200);

        // Divider bounds: CLK_DIV = 2 and 255 in parallel
        @(negedge clk);
        wr_d[1] = 24'h000803; wr_d[2] = 24'h000803;
        wr_en[1] = 1'b1; wr_en[2] = 1'b1;
        @(negedge clk);
        wr_en[1] = 1'b0; wr_en[2] = 1'b0;
        wait_idle(1, 300);
        wait_idle(2, 14000);
        chk("div2_sclk_period", 1, 32'(sclk_per_v[1]), 32'd4);
        chk("div2_busy_len", 1, 32'(busy_len_v[1]), 32'd104);
        chk("div2_csn_low", 1, 32'(csn_len_v[1]), 32'd100);
        chk("div255_sclk_period", 2, 32'(sclk_per_v[2]), 32'd510);
        chk("div255_busy_len", 2, 32'(busy_len_v[2]), 32'd13260);
        chk("div255_csn_low", 2, 32'(csn_len_v[2]), 32'd12750);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
